lsu_unit: RTL and testbench

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_unit.sv | 123 ++++++++++++
 tb/tb_lsu_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory op per visit to IDLE, drives a
// request/grant/rvalid bus, and returns aligned, extended load data.
module lsu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_fault,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic        op_fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  // Decode of the incoming op; funct3[1:0] encodes the access size.
  always_comb begin
    logic illegal;
    logic misaligned;
    if (lsu_we) illegal = (lsu_funct3 == 3'b011) || lsu_funct3[2];
    else        illegal = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11);
    misaligned = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                 ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
    op_fault = illegal || misaligned;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (lsu_valid)  state_next = op_fault ? DONE : REQ;
      REQ:  if (mem_gnt)    state_next = we_q ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_next = DONE;
      DONE:                 state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fault_q   <= 1'b0;
      lsu_rdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && lsu_valid) fault_q <= op_fault;
      if (state == WAIT && mem_rvalid) lsu_rdata <= load_data;
    end
  end

  // NOTE: the op payload is only read after it has been captured in IDLE,
  // so these registers need no reset and stay out of the reset path.
  always_ff @(posedge clk) begin
    if (state == IDLE && lsu_valid) begin
      we_q     <= lsu_we;
      funct3_q <= lsu_funct3;
      addr_q   <= lsu_addr;
      wdata_q  <= lsu_wdata;
    end
  end

  assign lsu_busy  = (state != IDLE);
  assign lsu_done  = (state == DONE);
  assign lsu_fault = lsu_done && fault_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    mem_wstrb = 4'b0000;
    if (mem_we) begin
      case (funct3_q[1:0])
        2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the access rules.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_fault;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'd0;

  lsu_unit dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_fault(lsu_fault),
    .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: size = funct3 mod 4 (0 byte, 1 half, 2 word).
  function automatic bit m_fault(bit we, int f3, longint unsigned addr);
    bit illegal;
    bit mis;
    illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    mis = ((f3 % 4) == 1 && (addr % 2) != 0) || ((f3 % 4) == 2 && (addr % 4) != 0);
    return illegal || mis;
  endfunction

  function automatic logic [31:0] m_load(int f3, longint unsigned addr, longint unsigned word);
    longint v;
    case (f3 % 4)
      0: begin
        v = (word / (longint'(1) << (8 * (addr % 4)))) % 256;
        if (f3 == 0 && v >= 128) v = v - 256;
      end
      1: begin
        v = (word / (longint'(1) << (16 * ((addr % 4) / 2)))) % 65536;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(int f3, longint unsigned wd);
    case (f3 % 4)
      0:       return 32'((wd % 256) * 32'h0101_0101);
      1:       return 32'((wd % 65536) * 32'h0001_0001);
      default: return 32'(wd);
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(int f3, longint unsigned addr);
    case (f3 % 4)
      0:       return 4'(1 << (addr % 4));
      1:       return 4'(3 << (2 * ((addr % 4) / 2)));
      default: return 4'hF;
    endcase
  endfunction

  // Issue one op from a negedge; acts as the memory with gnt/rvalid delays.
  task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword,
                        input int gd, input int rd, input string tag);
    bit was_done, exp_f, granted, rv_sent;
    int reqc, waitc, done_cyc, exp_cyc;
    was_done = lsu_done;
    exp_f = m_fault(we, int'(f3), longint'(addr));
    granted = 0; rv_sent = 0; reqc = 0; waitc = 0; done_cyc = -1;
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(posedge clk); #1;
    if (was_done) begin
      check({tag, "_ignored_in_done"}, 32'(lsu_busy), 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "_accept_busy"}, 32'(lsu_busy), 32'd1);
    lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
    lsu_funct3 = 3'($urandom); lsu_we = 1'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mem_gnt) begin granted = 1; mem_gnt = 1'b0; end
      if (mem_rvalid) begin rv_sent = 1; mem_rvalid = 1'b0; mem_rdata = $urandom; end
      if (lsu_done) begin done_cyc = cyc; break; end
      if (!exp_f && !granted) begin
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_we"}, 32'(mem_we), 32'(we));
        check({tag, "_wstrb"}, 32'(mem_wstrb), we ? 32'(m_wstrb(int'(f3), longint'(addr))) : 32'd0);
        if (we) check({tag, "_wdata"}, mem_wdata, m_wdata(int'(f3), longint'(wd)));
        if (reqc == gd) mem_gnt = 1'b1;
        reqc++;
      end else if (!exp_f && !we && !rv_sent) begin
        check({tag, "_wait_req"}, 32'(mem_req), 32'd0);
        if (waitc == rd) begin mem_rvalid = 1'b1; mem_rdata = rword; end
        waitc++;
      end
    end
    if (!exp_f && !we) model_rdata = m_load(int'(f3), longint'(addr), longint'(rword));
    exp_cyc = exp_f ? 1 : (we ? gd + 2 : gd + rd + 3);
    check({tag, "_latency"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, "_fault"}, 32'(lsu_fault), 32'(exp_f));
    check({tag, "_done_bus_idle"}, {31'd0, mem_req} | 32'(mem_wstrb) | 32'(mem_we), 32'd0);
    check({tag, "_rdata"}, lsu_rdata, model_rdata);
  endtask

  initial begin
    rst = 1'b1; lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h100; lsu_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(lsu_busy), 32'd0);
    check("rst_done_fault", {30'd0, lsu_done, lsu_fault}, 32'd0);
    check("rst_bus", {27'd0, mem_req, mem_wstrb}, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    rst = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(lsu_busy), 32'd0);

    run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 0, "lb_ext");
    check("lb_ext_value", lsu_rdata, 32'hFFFF_FF80);
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 0, 0, "sh_lanes");
    run_op(1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0, 0, "lw_misalign");
    check("lw_misalign_keep", lsu_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'b101, 32'h0000_4002, 32'd0, 32'hBEEF_0000, 3, 0, "lhu_stall");
    check("lhu_value", lsu_rdata, 32'h0000_BEEF);

    // Spurious bus responses in IDLE, then back-to-back ops.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    check("spur_busy", 32'(lsu_busy), 32'd0);
    check("spur_rdata", lsu_rdata, 32'h0000_BEEF);
    run_op(1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 32'd0, 0, 0, "sw_b2b");
    run_op(1'b0, 3'b010, 32'h0000_5004, 32'd0, 32'h0BAD_F00D, 1, 2, "lw_b2b");

    // Reset while the load waits for rvalid: op abandoned.
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 32'h6001;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(negedge clk); mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    check("wait_rst_pre_busy", 32'(lsu_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    model_rdata = 32'd0;
    check("wait_rst_idle", 32'(lsu_busy), 32'd0);
    @(negedge clk); mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_rst_no_done", 32'(lsu_done), 32'd0);
      check("wait_rst_rdata", lsu_rdata, 32'd0);
      @(negedge clk);
    end

    // Reset while the store sits in REQ.
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h7000;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(negedge clk);
    check("req_rst_pre_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b1;
    check("req_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk); mem_gnt = 1'b0;
    check("req_rst_no_done", {30'd0, lsu_done, lsu_busy}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) @(negedge clk);
      run_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
